// File: rtl/time_announce_ctrl_if.sv
// Signal bundle between the time-announce sequencer and its surroundings
// (GPS parser, digit converter, voice player, user key).
interface time_announce_ctrl_if;
   localparam int unsigned TIME_W = 18;
   localparam int unsigned DIG_W  = 4;

   logic              gps_valid;
   logic [TIME_W-1:0] gps_time;
   logic              key_req;
   logic              conv_done;
   logic [DIG_W-1:0]  shi_1;
   logic [DIG_W-1:0]  shi_2;
   logic [DIG_W-1:0]  fen_1;
   logic [DIG_W-1:0]  fen_2;
   logic              play_busy;
   logic [TIME_W-1:0] conv_time;
   logic              conv_start;
   logic [DIG_W-1:0]  play_code;
   logic              play_req;
   logic              busy;
   logic              err;

   // Sequencer side
   modport master (
      input  gps_valid, gps_time, key_req, conv_done,
      input  shi_1, shi_2, fen_1, fen_2, play_busy,
      output conv_time, conv_start, play_code, play_req, busy, err
   );

   // Environment side (parser, converter, player, key)
   modport slave (
      output gps_valid, gps_time, key_req, conv_done,
      output shi_1, shi_2, fen_1, fen_2, play_busy,
      input  conv_time, conv_start, play_code, play_req, busy, err
   );
endinterface

// File: rtl/time_announce_ctrl.sv
// Time-announce sequencer: snapshots the latest GPS time, runs one conversion and
// plays "hh dian mm fen". Optional macro TIME_CONV_CHECK_EN also waits for conv_done.
module time_announce_ctrl #(
   parameter int unsigned CONV_WAIT  = 32,
   parameter int unsigned START_HOLD = 2,
   parameter int unsigned TIMEOUT    = 1024
) (
   input logic                  clk,
   input logic                  rst_n,
   time_announce_ctrl_if.master bus
);
   localparam int unsigned TIME_W   = 18;
   localparam int unsigned DIG_W    = 4;
   localparam int unsigned NTOK     = 6;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned TIME_MAX = 235959;
   localparam int unsigned CAP_AT   = CONV_WAIT - START_HOLD;
   localparam int unsigned CNT_MAX  = CONV_WAIT + TIMEOUT;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [DIG_W-1:0] TOK_DIAN  = DIG_W'(10);
   localparam logic [DIG_W-1:0] TOK_FEN   = DIG_W'(11);
   localparam logic [DIG_W-1:0] TOK_NOSIG = DIG_W'(12);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_CONV,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         key_hist_q, key_hist_d;
   logic [TIME_W-1:0]  time_q, time_d;
   logic               has_fix_q, has_fix_d;
   logic [DIG_W-1:0]   tok_q [NTOK];
   logic [DIG_W-1:0]   tok_d [NTOK];
   logic [IDX_W-1:0]   tok_idx_q, tok_idx_d;
   logic [TIME_W-1:0]  conv_time_q, conv_time_d;
   logic               conv_start_q, conv_start_d;
   logic [DIG_W-1:0]   play_code_q, play_code_d;
   logic               play_req_q, play_req_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic               key_edge_c;
   logic               gps_ok_c;
   logic               digits_ok_c;
   logic               cap_now_c;
   logic               cap_tmo_c;

   assign key_edge_c  = key_hist_q[0] & ~key_hist_q[1];
   assign gps_ok_c    = bus.gps_valid && (bus.gps_time <= TIME_W'(TIME_MAX));
   assign digits_ok_c = (bus.shi_1 <= DIG_W'(2)) && (bus.shi_2 <= DIG_W'(9)) &&
                        (bus.fen_1 <= DIG_W'(9)) && (bus.fen_2 <= DIG_W'(9));

   // Capture decision: strictly at CONV_WAIT, or gated on the converter's done flag
`ifdef TIME_CONV_CHECK_EN
   assign cap_now_c = (cnt_q >= CNT_W'(CAP_AT)) && bus.conv_done;
   assign cap_tmo_c = (cnt_q >= CNT_W'(CAP_AT + TIMEOUT)) && !bus.conv_done;
`else
   logic unused_conv_done;
   assign unused_conv_done = bus.conv_done;
   assign cap_now_c = (cnt_q >= CNT_W'(CAP_AT));
   assign cap_tmo_c = 1'b0;
`endif

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d      = state_q;
      key_hist_d   = {key_hist_q[0], bus.key_req};
      time_d       = time_q;
      has_fix_d    = has_fix_q;
      tok_d        = tok_q;
      tok_idx_d    = tok_idx_q;
      conv_time_d  = conv_time_q;
      conv_start_d = 1'b0;
      play_code_d  = play_code_q;
      play_req_d   = 1'b0;
      err_d        = err_q;

      if (gps_ok_c) begin
         time_d    = bus.gps_time;
         has_fix_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (key_edge_c) begin
               err_d = 1'b0;
               // has_fix_d so a fix arriving with the key edge is honoured
               if (has_fix_d) begin
                  state_d = S_LOAD;
               end else begin
                  tok_idx_d        = IDX_W'(NTOK - 1);
                  tok_d[NTOK - 1]  = TOK_NOSIG;
                  state_d          = S_ISSUE;
               end
            end
         end
         S_LOAD: begin
            conv_time_d  = time_q;
            conv_start_d = 1'b1;
            state_d      = S_START;
         end
         S_START: begin
            if (cnt_q >= CNT_W'(START_HOLD - 1)) begin
               state_d = S_WAIT_CONV;
            end else begin
               conv_start_d = 1'b1;
            end
         end
         S_WAIT_CONV: begin
            if (cap_now_c) begin
               if (!digits_ok_c) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tok_d[0]  = bus.shi_1;
                  tok_d[1]  = bus.shi_2;
                  tok_d[2]  = TOK_DIAN;
                  tok_d[3]  = bus.fen_1;
                  tok_d[4]  = bus.fen_2;
                  tok_d[5]  = TOK_FEN;
                  tok_idx_d = '0;
                  state_d   = S_ISSUE;
               end
            end else if (cap_tmo_c) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (!bus.play_busy) begin
               play_code_d = tok_q[tok_idx_q];
               play_req_d  = 1'b1;
               state_d     = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (bus.play_busy) begin
               state_d = S_WAIT_FIN;
            end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WAIT_FIN: begin
            if (!bus.play_busy) begin
               if (tok_idx_q == IDX_W'(NTOK - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  tok_idx_d = tok_idx_q + 1'b1;
                  state_d   = S_ISSUE;
               end
            end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Shared wait counter: restarts on every state change, saturates
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(CNT_MAX)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         key_hist_q   <= '0;
         time_q       <= '0;
         has_fix_q    <= 1'b0;
         for (int unsigned i = 0; i < NTOK; i++) tok_q[i] <= '0;
         tok_idx_q    <= '0;
         conv_time_q  <= '0;
         conv_start_q <= 1'b0;
         play_code_q  <= '0;
         play_req_q   <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         key_hist_q   <= key_hist_d;
         time_q       <= time_d;
         has_fix_q    <= has_fix_d;
         tok_q        <= tok_d;
         tok_idx_q    <= tok_idx_d;
         conv_time_q  <= conv_time_d;
         conv_start_q <= conv_start_d;
         play_code_q  <= play_code_d;
         play_req_q   <= play_req_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign bus.conv_time  = conv_time_q;
   assign bus.conv_start = conv_start_q;
   assign bus.play_code  = play_code_q;
   assign bus.play_req   = play_req_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_time_announce_ctrl.sv
// Scoreboard bench for time_announce_ctrl with behavioural converter and voice player.
module tb_time_announce_ctrl;
   localparam int unsigned TIMEOUT = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   time_announce_ctrl_if ifc ();

   time_announce_ctrl #(
      .CONV_WAIT (32),
      .START_HOLD(2),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
   );

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];
   bit player_stuck = 1'b0;
   bit cv_done_low  = 1'b0;
   bit cv_bad       = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every play strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && ifc.play_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_play: got code %0d expected no play_req", ifc.play_code);
         end else begin
            check("play_code", int'(ifc.play_code), int'(exp_q.pop_front()));
         end
      end
   end

   // Voice player: acks ~3 cycles after the strobe, busy for 10 cycles
   initial begin
      ifc.play_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.play_req && !player_stuck) begin
            repeat (2) @(negedge clk);
            ifc.play_busy = 1'b1;
            repeat (10) @(negedge clk);
            ifc.play_busy = 1'b0;
         end
      end
   end

   // Converter: UTC+8 digits ready 20 cycles after conv_start rises
   initial begin
      int t, hh, mm, bh;
      ifc.conv_done = 1'b0;
      ifc.shi_1 = '0; ifc.shi_2 = '0; ifc.fen_1 = '0; ifc.fen_2 = '0;
      forever begin
         @(posedge ifc.conv_start);
         ifc.conv_done = 1'b0;
         @(negedge clk);
         t = int'(ifc.conv_time);
         repeat (20) @(negedge clk);
         hh = t / 10000;
         mm = (t / 100) % 100;
         bh = (hh + 8) % 24;
         ifc.shi_1 = cv_bad ? 4'd3 : 4'(bh / 10);
         ifc.shi_2 = 4'(bh % 10);
         ifc.fen_1 = 4'(mm / 10);
         ifc.fen_2 = 4'(mm % 10);
         ifc.conv_done = !cv_done_low;
      end
   end

   task automatic gps(input int v);
      @(negedge clk);
      ifc.gps_valid = 1'b1;
      ifc.gps_time  = 18'(v);
      @(negedge clk);
      ifc.gps_valid = 1'b0;
   endtask

   task automatic key_press();
      @(negedge clk);
      ifc.key_req = 1'b1;
      repeat (3) @(negedge clk);
      ifc.key_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic push6(input int a, input int b, input int c, input int d);
      exp_q.push_back(4'(a));
      exp_q.push_back(4'(b));
      exp_q.push_back(4'd10);
      exp_q.push_back(4'(c));
      exp_q.push_back(4'(d));
      exp_q.push_back(4'd11);
   endtask

   task automatic wait_done(input string name, input int max);
      int n;
      n = 0;
      while (!ifc.busy && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (ifc.busy && n < max) begin @(negedge clk); n++; end
      check({name, "_busy_end"}, int'(ifc.busy), 0);
      repeat (3) @(negedge clk);
      check({name, "_sb_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int n;
      ifc.gps_valid = 1'b0;
      ifc.gps_time  = '0;
      ifc.key_req   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_conv_time", int'(ifc.conv_time), 0);
      check("rst_conv_start", int'(ifc.conv_start), 0);
      check("rst_play_code", int'(ifc.play_code), 0);
      check("rst_play_req", int'(ifc.play_req), 0);
      check("rst_busy", int'(ifc.busy), 0);
      check("rst_err", int'(ifc.err), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // No fix since reset: only "no signal"
      exp_q.push_back(4'd12);
      key_press();
      wait_done("nofix", 200);
      check("nofix_err", int'(ifc.err), 0);

      // 04:30:15 UTC -> 12:30
      gps(43015);
      push6(1, 2, 3, 0);
      key_press();
      wait_done("t1", 400);
      check("t1_err", int'(ifc.err), 0);

      // 23:59:59 snapshot stays while 12:00:00 arrives mid-phrase
      gps(235959);
      push6(0, 7, 5, 9);
      key_press();
      repeat (10) @(negedge clk);
      gps(120000);
      wait_done("t3a", 400);
      push6(2, 0, 0, 0);
      key_press();
      wait_done("t3b", 400);

      // Repeated key edges while busy and an out-of-range time are ignored
      gps(101500);
      push6(1, 8, 1, 5);
      key_press();
      repeat (20) @(negedge clk);
      key_press();
      gps(250000);
      key_press();
      key_press();
      wait_done("t5a", 400);
      push6(1, 8, 1, 5);
      key_press();
      wait_done("t5b", 400);

      // Player never acks: err after TIMEOUT+1 cycles, cleared by next request
      player_stuck = 1'b1;
      exp_q.push_back(4'd1);
      key_press();
      n = 0;
      while (!ifc.play_req && n < 200) begin @(negedge clk); n++; end
      check("t4_play_req_seen", int'(ifc.play_req), 1);
      n = 0;
      while (!ifc.err && n < int'(TIMEOUT) + 10) begin @(negedge clk); n++; end
      check("t4_timeout_cycles", n, int'(TIMEOUT) + 1);
      @(negedge clk);
      check("t4_busy", int'(ifc.busy), 0);
      check("t4_err", int'(ifc.err), 1);
      player_stuck = 1'b0;
      push6(1, 8, 1, 5);
      key_press();
      check("t4_err_cleared", int'(ifc.err), 0);
      wait_done("t4b", 400);

      // Invalid hour tens digit from the converter: error, nothing played
      cv_bad = 1'b1;
      key_press();
      wait_done("bad_digit", 200);
      check("bad_digit_err", int'(ifc.err), 1);
      cv_bad = 1'b0;

      // Converter never raises done
      gps(0);
      cv_done_low = 1'b1;
`ifdef TIME_CONV_CHECK_EN
      key_press();
      wait_done("t6", 3000);
      check("t6_err", int'(ifc.err), 1);
`else
      push6(0, 8, 0, 0);
      key_press();
      wait_done("t6", 400);
      check("t6_err", int'(ifc.err), 0);
`endif
      cv_done_low = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
